// File: rtl/bus_dispatcher.sv
// Packs register-access requests into frames and routes each one to a per-switch FIFO.
// The block is a one-entry pipeline with valid/ready handshake, full backpressure and saturating status counters.
module bus_dispatcher #(
  parameter int NUM_SW_INST = 5,
  parameter int SW_ADDR_W   = 3,
  parameter int REG_ADDR_W  = 5,
  parameter int W_WIDTH     = 8,
  parameter int ID_WIDTH    = 8,
  parameter int FRAME_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_in,
  input  logic                            valid,
  output logic                            ready,
  input  logic                            wr_rd_op,
  input  logic [ID_WIDTH-1:0]             op_id,
  input  logic [SW_ADDR_W+REG_ADDR_W-1:0] addr_in,
  input  logic [W_WIDTH-1:0]              wr_data_in,
  input  logic [NUM_SW_INST-1:0]          fifo_full,
  output logic [FRAME_WIDTH-1:0]          frame_out,
  output logic [NUM_SW_INST-1:0]          fifo_wr_en,
  output logic                            addr_err,
  input  logic                            clr_cnt,
  output logic [CNT_WIDTH-1:0]            err_cnt,
  output logic [CNT_WIDTH-1:0]            stall_cnt
);

  localparam int PAYLOAD_W = REG_ADDR_W + 1 + W_WIDTH + ID_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t                  state;
  logic [SW_ADDR_W-1:0]    tgt;
  logic [FRAME_WIDTH-1:0]  frame_q;
  logic                    addr_err_q;

  logic [SW_ADDR_W-1:0]    sw;
  logic [REG_ADDR_W-1:0]   reg_addr;
  logic                    in_range;
  logic                    pending;
  logic                    fire;
  logic                    accept;
  logic                    load;
  logic [FRAME_WIDTH-1:0]  frame_next;

  assign sw       = addr_in[SW_ADDR_W+REG_ADDR_W-1 -: SW_ADDR_W];
  assign reg_addr = addr_in[REG_ADDR_W-1:0];
  assign in_range = {1'b0, sw} < (SW_ADDR_W+1)'(NUM_SW_INST);

  assign pending = (state != IDLE);
  assign fire    = pending && !fifo_full[tgt];
  // Gated by rst so the source never sees a handshake while the block is held in reset
  assign ready   = !rst && en_in && ((state == IDLE) || fire);
  assign accept  = valid && ready;
  assign load    = accept && in_range;

  assign fifo_wr_en = fire ? (NUM_SW_INST'(1) << tgt) : '0;
  assign frame_out  = frame_q;
  assign addr_err   = addr_err_q;

  always_comb begin
    frame_next = '0;
    frame_next[PAYLOAD_W-1:0] = {reg_addr, wr_rd_op, wr_data_in, op_id};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tgt        <= '0;
      frame_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= accept && !in_range;
      case (state)
        IDLE: begin
          if (load) begin
            state   <= SEND;
            frame_q <= frame_next;
            tgt     <= sw;
          end
        end
        default: begin
          if (fire) begin
            if (load) begin
              state   <= SEND;
              frame_q <= frame_next;
              tgt     <= sw;
            end else begin
              state   <= IDLE;
              frame_q <= '0;
            end
          end else begin
            state <= WAIT;
          end
        end
      endcase
    end
  end

  // Only WAIT cycles count as stalls; the first blocked cycle sits in SEND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && !in_range && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
      if ((state == WAIT) && !fire && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_dispatcher.sv
// Scoreboard bench for bus_dispatcher: stimulus pushes expected FIFO writes / address errors,
// a negedge monitor pops and compares whenever the DUT strobes a write or an error.
module tb_bus_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in;
  logic        valid;
  logic        ready;
  logic        wr_rd_op;
  logic [7:0]  op_id;
  logic [7:0]  addr_in;
  logic [7:0]  wr_data_in;
  logic [4:0]  fifo_full;
  logic [31:0] frame_out;
  logic [4:0]  fifo_wr_en;
  logic        addr_err;
  logic        clr_cnt;
  logic [15:0] err_cnt;
  logic [15:0] stall_cnt;

  typedef struct {
    logic [4:0]  wr_en;
    logic [31:0] frame;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bus_dispatcher dut (
    .clk(clk), .rst(rst), .en_in(en_in), .valid(valid), .ready(ready),
    .wr_rd_op(wr_rd_op), .op_id(op_id), .addr_in(addr_in), .wr_data_in(wr_data_in),
    .fifo_full(fifo_full), .frame_out(frame_out), .fifo_wr_en(fifo_wr_en),
    .addr_err(addr_err), .clr_cnt(clr_cnt), .err_cnt(err_cnt), .stall_cnt(stall_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame model: {pad, reg[4:0], wr, data, id}
  function automatic exp_t model(input logic [7:0] a, input logic w,
                                 input logic [7:0] d, input logic [7:0] id);
    exp_t e;
    logic [2:0] s;
    s = a[7:5];
    e.frame = {10'b0, a[4:0], w, d, id};
    e.err   = (s >= 3'd5);
    e.wr_en = e.err ? 5'b0 : (5'b00001 << s);
    return e;
  endfunction

  // Presents one request and holds it until accepted; returns at accept edge + 1
  task automatic applyStimulus(input logic [7:0] a, input logic w, input logic [7:0] d,
                               input logic [7:0] id, output int tries);
    bit done;
    done  = 1'b0;
    tries = 0;
    valid = 1'b1; addr_in = a; wr_rd_op = w; wr_data_in = d; op_id = id;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      tries++;
      if (ready) begin
        done = 1'b1;
        expq.push_back(model(a, w, d, id));
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: got no ready expected ready for addr %0h", a);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (fifo_wr_en != 5'b0 || addr_err)) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL mon_unexpected: got wr_en=%0h err=%0b expected no event",
                   fifo_wr_en, addr_err);
        end else begin
          e = expq.pop_front();
          checkOutput("mon_wr_en", {27'b0, fifo_wr_en}, {27'b0, e.wr_en});
          checkOutput("mon_err", {31'b0, addr_err}, {31'b0, e.err});
          if (!e.err) checkOutput("mon_frame", frame_out, e.frame);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int tries;
    rst = 1'b1; en_in = 1'b1; valid = 1'b0; wr_rd_op = 1'b0; op_id = '0;
    addr_in = '0; wr_data_in = '0; fifo_full = '0; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_frame", frame_out, 32'h0);
    checkOutput("rst_wr_en", {27'b0, fifo_wr_en}, 32'h0);
    checkOutput("rst_ready", {31'b0, ready}, 32'h0);
    checkOutput("rst_cnts", {err_cnt, stall_cnt}, 32'h0);
    checkOutput("rst_addr_err", {31'b0, addr_err}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single write");
    applyStimulus(8'h43, 1'b1, 8'hA5, 8'h11, tries);
    checkOutput("single_frame", frame_out, 32'h0007A511);
    checkOutput("single_wr_en", {27'b0, fifo_wr_en}, 32'h4);
    @(posedge clk); #1;
    checkOutput("single_idle_frame", frame_out, 32'h0);
    checkOutput("single_idle_ready", {31'b0, ready}, 32'h1);

    $display("[TB] backpressure");
    fifo_full = 5'b00010;
    applyStimulus(8'h2A, 1'b0, 8'h00, 8'h22, tries);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("bp_ready", {31'b0, ready}, 32'h0);
      checkOutput("bp_frame", frame_out, 32'h00140022);
      @(posedge clk); #1;
    end
    checkOutput("bp_stall", {16'b0, stall_cnt}, 32'd2);
    fifo_full = 5'b0;
    #1;
    checkOutput("bp_ready_back", {31'b0, ready}, 32'h1);
    @(posedge clk); #1;
    checkOutput("bp_stall_after", {16'b0, stall_cnt}, 32'd2);
    checkOutput("bp_idle_frame", frame_out, 32'h0);

    $display("[TB] back-to-back");
    fifo_full = 5'b11110;
    applyStimulus(8'h05, 1'b1, 8'h10, 8'h01, tries);
    fifo_full = 5'b0;
    applyStimulus(8'h26, 1'b1, 8'h20, 8'h02, tries);
    checkOutput("b2b_ready1", tries, 1);
    applyStimulus(8'h47, 1'b0, 8'h30, 8'h03, tries);
    checkOutput("b2b_ready2", tries, 1);
    applyStimulus(8'h68, 1'b1, 8'h40, 8'h04, tries);
    checkOutput("b2b_ready3", tries, 1);
    @(posedge clk); #1;

    $display("[TB] address error");
    applyStimulus(8'hE0, 1'b1, 8'h55, 8'h66, tries);
    checkOutput("err_wr_en", {27'b0, fifo_wr_en}, 32'h0);
    checkOutput("err_cnt", {16'b0, err_cnt}, 32'd1);
    checkOutput("err_frame", frame_out, 32'h0);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checkOutput("err_cnt_clr", {err_cnt, stall_cnt}, 32'h0);

    $display("[TB] reset while blocked");
    fifo_full = 5'b01000;
    applyStimulus(8'h61, 1'b1, 8'h77, 8'h33, tries);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rw_stall", {16'b0, stall_cnt}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rw_frame", frame_out, 32'h0);
    checkOutput("rw_ready", {31'b0, ready}, 32'h0);
    checkOutput("rw_stall_rst", {16'b0, stall_cnt}, 32'h0);
    expq.delete();
    fifo_full = 5'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rw_no_stale", {27'b0, fifo_wr_en}, 32'h0);

    $display("[TB] enable low drains");
    fifo_full = 5'b00001;
    applyStimulus(8'h02, 1'b1, 8'h9C, 8'h44, tries);
    en_in = 1'b0; fifo_full = 5'b0;
    valid = 1'b1; addr_in = 8'h22; wr_rd_op = 1'b1; wr_data_in = 8'h12; op_id = 8'h55;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("en_ready", {31'b0, ready}, 32'h0);
      @(posedge clk); #1;
    end
    checkOutput("en_drained", frame_out, 32'h0);
    en_in = 1'b1;
    applyStimulus(8'h22, 1'b1, 8'h12, 8'h55, tries);
    checkOutput("en_accept", tries, 1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
